// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one DataMem port between the core (r0) and a DMA loader (r1).
// A requester may lock the port for an atomic sequence; a lock timeout forces release.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out,
  output logic          lock_err
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  localparam int            TW   = $clog2(MAX_LOCK);
  localparam logic [TW-1:0] TMAX = TW'(MAX_LOCK - 1);

  state_t        state;
  logic          last;
  logic [TW-1:0] timer;
  logic          blk0, blk1;

  logic elig0, elig1;
  logic win;          // 0 = r0, 1 = r1
  logic grant;
  logic win_lock, win_blk;
  logic owner, owner_lock;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    elig0 = r0_req && (state != LOCK1);
    elig1 = r1_req && (state != LOCK0);
    win   = 1'b0;
    if (elig0 && elig1) win = ~last;
    else if (elig1)     win = 1'b1;
    // Reset gates grants combinationally so no access leaks out while init_n is low.
    grant      = init_n && (elig0 || elig1);
    win_lock   = win ? r1_lock : r0_lock;
    win_blk    = win ? blk1 : blk0;
    owner      = (state == LOCK1);
    owner_lock = owner ? r1_lock : r0_lock;
  end

  assign r0_gnt   = grant && !win;
  assign r1_gnt   = grant && win;
  assign mem_wen  = grant && (win ? r1_we : r0_we);
  assign mem_addr = grant ? (win ? r1_addr : r0_addr) : '0;
  assign mem_in   = grant ? (win ? r1_wdata : r0_wdata) : '0;

  // NOTE: sequential state uses non-blocking assignments; later assignments in the block take precedence.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      timer     <= '0;
      blk0      <= 1'b0;
      blk1      <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      lock_err  <= 1'b0;
    end else begin
      lock_err  <= 1'b0;
      r0_rvalid <= r0_gnt && !r0_we;
      r1_rvalid <= r1_gnt && !r1_we;
      if (r0_gnt && !r0_we) r0_rdata <= mem_out;
      if (r1_gnt && !r1_we) r1_rdata <= mem_out;
      if (grant) last <= win;
      if (!r0_lock) blk0 <= 1'b0;
      if (!r1_lock) blk1 <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant && win_lock && !win_blk) begin
            state <= win ? LOCK1 : LOCK0;
            timer <= '0;
          end
        end
        LOCK0, LOCK1: begin
          if (!owner_lock) begin
            state <= IDLE;
          end else if (timer == TMAX) begin
            // Forced release: hand the next tie to the other side and bar relock.
            state    <= IDLE;
            lock_err <= 1'b1;
            last     <= owner;
            if (owner) blk1 <= 1'b1;
            else       blk0 <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
